// File: rtl/sobel_operator_if.sv
// Window-in / result-out handshake bundle for sobel_operator.
// master = upstream controller + output writer side, slave = the gradient engine.
interface sobel_operator_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               start_calc;
  logic [7:0]         windowBuffer [0:8];
  logic               calc_ready;
  logic               out_valid;
  logic [7:0]         pixel_out;
  logic               out_ack;
  logic [COUNT_W-1:0] pixel_count;

  modport master (
    output start_calc,
    output windowBuffer,
    output out_ack,
    input  calc_ready,
    input  out_valid,
    input  pixel_out,
    input  pixel_count
  );

  modport slave (
    input  start_calc,
    input  windowBuffer,
    input  out_ack,
    output calc_ready,
    output out_valid,
    output pixel_out,
    output pixel_count
  );
endinterface

// File: rtl/sobel_operator.sv
// sobel_operator: three-stage pipelined |Gx|+|Gy| engine with valid/ack backpressure.
// Define SOBEL_THRESH_EN to binarize the saturated magnitude against THRESH.
module sobel_operator #(
  parameter int unsigned COUNT_W = 16,
  parameter logic [7:0]  THRESH  = 8'd128
) (
  input logic           clk,
  input logic           n_rst,
  sobel_operator_if.slave bus
);

`ifdef SOBEL_THRESH_EN
  localparam bit THRESH_EN = 1'b1;
`else
  localparam bit THRESH_EN = 1'b0;
`endif

  logic       r_s1Valid;
  logic [9:0] r_xPos, r_xNeg, r_yPos, r_yNeg;
  logic       r_s2Valid;
  logic [9:0] r_absGx, r_absGy;
  logic       r_outValid;
  logic [7:0] r_pixelOut;
  logic [COUNT_W-1:0] r_pixelCount;

  logic w_outAck, w_outFree, w_s2Advance, w_s2Free, w_s1Advance, w_calcReady, w_accept;
  logic [9:0]  w_xPos, w_xNeg, w_yPos, w_yNeg;
  logic [10:0] w_gx, w_gy;
  logic [9:0]  w_absGx, w_absGy;
  logic [10:0] w_sum;
  logic [7:0]  w_sat, w_result;

  // Backpressure ripples from the output register back to the accept point in one cycle.
  assign w_outAck    = r_outValid && bus.out_ack;
  assign w_outFree   = !r_outValid || bus.out_ack;
  assign w_s2Advance = r_s2Valid && w_outFree;
  assign w_s2Free    = !r_s2Valid || w_s2Advance;
  assign w_s1Advance = r_s1Valid && w_s2Free;
  assign w_calcReady = !r_s1Valid || w_s1Advance;
  assign w_accept    = bus.start_calc && w_calcReady;

  assign w_xPos = {2'b00, bus.windowBuffer[2]} + {1'b0, bus.windowBuffer[5], 1'b0}
                + {2'b00, bus.windowBuffer[8]};
  assign w_xNeg = {2'b00, bus.windowBuffer[0]} + {1'b0, bus.windowBuffer[3], 1'b0}
                + {2'b00, bus.windowBuffer[6]};
  assign w_yPos = {2'b00, bus.windowBuffer[6]} + {1'b0, bus.windowBuffer[7], 1'b0}
                + {2'b00, bus.windowBuffer[8]};
  assign w_yNeg = {2'b00, bus.windowBuffer[0]} + {1'b0, bus.windowBuffer[1], 1'b0}
                + {2'b00, bus.windowBuffer[2]};

  // Two's-complement differences; magnitudes never exceed 1020 so 10 bits suffice.
  assign w_gx    = {1'b0, r_xPos} - {1'b0, r_xNeg};
  assign w_gy    = {1'b0, r_yPos} - {1'b0, r_yNeg};
  assign w_absGx = w_gx[10] ? 10'(11'd0 - w_gx) : w_gx[9:0];
  assign w_absGy = w_gy[10] ? 10'(11'd0 - w_gy) : w_gy[9:0];

  assign w_sum    = {1'b0, r_absGx} + {1'b0, r_absGy};
  assign w_sat    = (w_sum > 11'd255) ? 8'hFF : w_sum[7:0];
  assign w_result = THRESH_EN ? ((w_sat >= THRESH) ? 8'hFF : 8'h00) : w_sat;

  // S1 captures the window only on the accept edge, so later window shifts are harmless.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s1Valid <= 1'b0;
      r_xPos    <= '0;
      r_xNeg    <= '0;
      r_yPos    <= '0;
      r_yNeg    <= '0;
    end else begin
      r_s1Valid <= w_accept || (r_s1Valid && !w_s1Advance);
      if (w_accept) begin
        r_xPos <= w_xPos;
        r_xNeg <= w_xNeg;
        r_yPos <= w_yPos;
        r_yNeg <= w_yNeg;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_s2Valid <= 1'b0;
      r_absGx   <= '0;
      r_absGy   <= '0;
    end else begin
      r_s2Valid <= w_s1Advance || (r_s2Valid && !w_s2Advance);
      if (w_s1Advance) begin
        r_absGx <= w_absGx;
        r_absGy <= w_absGy;
      end
    end
  end

  // Output register doubles as S3: an ack and a reload on the same edge keep out_valid high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_outValid   <= 1'b0;
      r_pixelOut   <= '0;
      r_pixelCount <= '0;
    end else begin
      r_outValid <= w_s2Advance || (r_outValid && !w_outAck);
      if (w_s2Advance) begin
        r_pixelOut <= w_result;
      end
      if (w_outAck) begin
        r_pixelCount <= r_pixelCount + 1'b1;
      end
    end
  end

  assign bus.calc_ready  = w_calcReady;
  assign bus.out_valid   = r_outValid;
  assign bus.pixel_out   = r_pixelOut;
  assign bus.pixel_count = r_pixelCount;

endmodule

// File: tb/tb_sobel_operator.sv
// Directed, table-driven bench for sobel_operator: single windows, streaming,
// backpressure, counter wrap and asynchronous reset.
module tb_sobel_operator;

  localparam int unsigned TB_COUNT_W = 4;

`ifdef SOBEL_THRESH_EN
  localparam bit BIN = 1'b1;
`else
  localparam bit BIN = 1'b0;
`endif

  typedef struct packed {
    logic [71:0] pixels;
    logic [7:0]  expMag;
    logic [7:0]  expBin;
  } vec_t;

  localparam int NUM_VEC = 14;

  logic clk;
  logic n_rst;
  vec_t vecs [NUM_VEC];
  int   checks;
  int   failures;
  logic [TB_COUNT_W-1:0] expCount;

  sobel_operator_if #(.COUNT_W(TB_COUNT_W)) bus ();

  sobel_operator #(.COUNT_W(TB_COUNT_W)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] mkWin(input logic [7:0] p0, input logic [7:0] p1,
                                        input logic [7:0] p2, input logic [7:0] p3,
                                        input logic [7:0] p4, input logic [7:0] p5,
                                        input logic [7:0] p6, input logic [7:0] p7,
                                        input logic [7:0] p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  function automatic logic [7:0] expOf(input int idx);
    return BIN ? vecs[idx].expBin : vecs[idx].expMag;
  endfunction

  task automatic applyStimulus(input logic [71:0] win, input logic start);
    for (int i = 0; i < 9; i++) bus.windowBuffer[i] = win[8*i +: 8];
    bus.start_calc = start;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One window with out_ack held high: accept, 3-edge latency, result, then ack.
  task automatic runVector(input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    applyStimulus(vecs[idx].pixels, 1'b1);
    checkOutput({tag, "_ready"}, 32'(bus.calc_ready), 32'd1);
    @(posedge clk); #1;
    applyStimulus(mkWin(8'd0, 8'd0, 8'd0, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0), 1'b0);
    checkOutput({tag, "_valid_k"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid_k1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput({tag, "_valid_k2"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_pixel"}, 32'(bus.pixel_out), 32'(expOf(idx)));
    @(posedge clk); #1;
    expCount = expCount + 1'b1;
    checkOutput({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, "_count"}, 32'(bus.pixel_count), 32'(expCount));
  endtask

  initial begin
    int bpIdx [4];
    checks   = 0;
    failures = 0;
    expCount = '0;

    //                         p0     p1     p2     p3     p4     p5     p6     p7     p8      mag      bin
    vecs[0]  = '{mkWin(8'd100,8'd100,8'd100,8'd100,8'd100,8'd100,8'd100,8'd100,8'd100), 8'd0,   8'd0};
    vecs[1]  = '{mkWin(8'd0,  8'd0,  8'd10, 8'd0,  8'd0,  8'd10, 8'd0,  8'd0,  8'd10),  8'd40,  8'd0};
    vecs[2]  = '{mkWin(8'd0,  8'd0,  8'd255,8'd0,  8'd0,  8'd255,8'd0,  8'd0,  8'd255), 8'd255, 8'd255};
    vecs[3]  = '{mkWin(8'd50, 8'd50, 8'd50, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0),   8'd200, 8'd255};
    vecs[4]  = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd30),  8'd60,  8'd0};
    vecs[5]  = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd255,8'd255,8'd255), 8'd255, 8'd255};
    vecs[6]  = '{mkWin(8'd200,8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0),   8'd255, 8'd255};
    vecs[7]  = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd127,8'd0,  8'd0,  8'd0),   8'd254, 8'd255};
    vecs[8]  = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd128,8'd0,  8'd0,  8'd0),   8'd255, 8'd255};
    vecs[9]  = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd64, 8'd0,  8'd0,  8'd0),   8'd128, 8'd255};
    vecs[10] = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd63, 8'd0,  8'd0,  8'd0),   8'd126, 8'd0};
    vecs[11] = '{mkWin(8'd0,  8'd60, 8'd0,  8'd70, 8'd0,  8'd0,  8'd0,  8'd0,  8'd0),   8'd255, 8'd255};
    vecs[12] = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd20, 8'd0),   8'd40,  8'd0};
    vecs[13] = '{mkWin(8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd0,  8'd10, 8'd0,  8'd0),   8'd20,  8'd0};

    n_rst       = 1'b0;
    bus.out_ack = 1'b0;
    applyStimulus('0, 1'b0);
    #1;
    checkOutput("rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_pixel", 32'(bus.pixel_out), 32'd0);
    checkOutput("rst_count", 32'(bus.pixel_count), 32'd0);
    checkOutput("rst_ready", 32'(bus.calc_ready), 32'd1);
    #20 n_rst = 1'b1;
    @(posedge clk); #1;

    bus.out_ack = 1'b1;
    for (int i = 0; i < NUM_VEC; i++) runVector(i);

    // Back-to-back stream: one result per cycle, calc_ready never drops.
    for (int t = 0; t < 7; t++) begin
      if (t < 5) begin
        applyStimulus(vecs[t + 1].pixels, 1'b1);
        checkOutput($sformatf("stream_ready%0d", t), 32'(bus.calc_ready), 32'd1);
      end else begin
        applyStimulus('0, 1'b0);
      end
      @(posedge clk); #1;
      if (t >= 2) begin
        checkOutput($sformatf("stream_valid%0d", t - 2), 32'(bus.out_valid), 32'd1);
        checkOutput($sformatf("stream_pixel%0d", t - 2), 32'(bus.pixel_out),
                    32'(expOf(t - 1)));
        if (t >= 3) expCount = expCount + 1'b1;
      end
    end
    @(posedge clk); #1;
    expCount = expCount + 1'b1;
    checkOutput("stream_drained", 32'(bus.out_valid), 32'd0);
    checkOutput("stream_count", 32'(bus.pixel_count), 32'(expCount));

    // Backpressure: three windows fill the pipe, the fourth is held off.
    bus.out_ack = 1'b0;
    bpIdx = '{1, 0, 2, 1};
    for (int j = 0; j < 3; j++) begin
      applyStimulus(vecs[bpIdx[j]].pixels, 1'b1);
      checkOutput($sformatf("bp_ready%0d", j), 32'(bus.calc_ready), 32'd1);
      @(posedge clk); #1;
    end
    applyStimulus(vecs[bpIdx[3]].pixels, 1'b1);
    checkOutput("bp_full", 32'(bus.calc_ready), 32'd0);
    @(posedge clk); #1;
    checkOutput("bp_still_full", 32'(bus.calc_ready), 32'd0);
    for (int j = 0; j < 4; j++) begin
      checkOutput($sformatf("bp_valid%0d", j), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("bp_pixel%0d", j), 32'(bus.pixel_out), 32'(expOf(bpIdx[j])));
      bus.out_ack = 1'b1;
      #1;
      if (j == 0) checkOutput("bp_recover", 32'(bus.calc_ready), 32'd1);
      @(posedge clk); #1;
      bus.out_ack = 1'b0;
      bus.start_calc = 1'b0;
      expCount = expCount + 1'b1;
    end
    checkOutput("bp_drained", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_count", 32'(bus.pixel_count), 32'(expCount));

    // Asynchronous reset with two windows in flight.
    applyStimulus(vecs[1].pixels, 1'b1);
    @(posedge clk); #1;
    applyStimulus(vecs[3].pixels, 1'b1);
    @(posedge clk); #1;
    bus.start_calc = 1'b0;
    @(posedge clk); #1;
    checkOutput("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("pre_rst_count", 32'(bus.pixel_count), 32'(expCount));
    #2 n_rst = 1'b0;
    #1;
    checkOutput("async_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_rst_pixel", 32'(bus.pixel_out), 32'd0);
    checkOutput("async_rst_count", 32'(bus.pixel_count), 32'd0);
    #3 n_rst = 1'b1;
    expCount = '0;
    @(posedge clk); #1;
    checkOutput("post_rst_empty", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("post_rst_still_empty", 32'(bus.out_valid), 32'd0);
    bus.out_ack = 1'b1;
    runVector(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
